fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, PC and address width.
REQ-002 Parameter DEPTH, 4, instruction queue entries; power of two, >=2.
REQ-003 Parameter RESET_PC, 32'h0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  XLEN  fetch address, word aligned.
REQ-008 imem_gnt  input  1  request accepted this cycle (imem_req && imem_gnt).
REQ-009 imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after accept.
REQ-010 imem_rdata  input  32  instruction word of the oldest outstanding request.
REQ-011 redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
REQ-012 redirect_pc  input  XLEN  redirect target.
REQ-013 instr_valid  output  1  queue head valid toward decode.
REQ-014 instr  output  32  queue head instruction.
REQ-015 instr_pc  output  XLEN  PC of queue head.
REQ-016 instr_ready  input  1  decode accepts head this cycle.

Function
REQ-017 State: fetch_pc, resp_pc (PC of the next expected response), outstanding count, drop count, FIFO of {pc, instr}, occupancy count.
REQ-018 imem_req = !reset && !redirect_valid && (count + outstanding < DEPTH); imem_addr = fetch_pc.
REQ-019 On accept: fetch_pc += 4 (modulo 2^XLEN), outstanding += 1.
REQ-020 On imem_rvalid: outstanding -= 1; if drop > 0, discard and decrement drop; otherwise push {resp_pc, imem_rdata} and increment resp_pc by 4.
REQ-021 A simultaneous accept and response leaves outstanding unchanged.
REQ-022 instr_valid = (count != 0). A pop occurs on instr_valid && instr_ready.
REQ-023 Push and pop in the same cycle SHALL be allowed, including when the queue is full (count == DEPTH) or empty with push.
REQ-024 Push to an empty queue becomes visible on instr_valid the following cycle; there is no same-cycle bypass.
REQ-025 With instr_ready low, instr and instr_pc SHALL hold stable while instr_valid = 1.
REQ-026 The credit rule (REQ-018) guarantees no push to a full queue without a pop.
REQ-027 A response with outstanding == 0 is a protocol violation; the bench flags it.
REQ-028 Redirect cycle: fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; resp_pc <= the same value; queue cleared; any pop and push that cycle are ignored.
REQ-029 Redirect cycle: drop <= outstanding minus any response arriving that cycle, so all in-flight stale responses are discarded.
REQ-030 Redirect during a nonzero drop count SHALL replace drop per REQ-029, with no double count.
REQ-031 Back-to-back redirects: the last one wins.
REQ-032 Throughput: one instruction per cycle sustained when imem_gnt = 1, memory latency <= DEPTH-1, and instr_ready = 1.

Reset
REQ-033 While reset = 1: imem_req = 0, instr_valid = 0.
REQ-034 Next cycle after reset: fetch_pc = resp_pc = RESET_PC; count, outstanding and drop = 0.
REQ-035 Reset mid-operation discards queue and in-flight state; responses arriving after reset are the memory's responsibility to suppress.
REQ-036 FIFO data storage need not be reset.

Structure
REQ-037 Shared package riscv_pkg holds XLEN, INSTR_W = 32, the default RESET_PC, and the fetch_entry_t struct {pc, instr}.
REQ-038 One sub-module, fetch_fifo (parameter DEPTH, element fetch_entry_t, with push, pop, flush, count), is instantiated once.
REQ-039 Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.

Verification
REQ-040 Reset, imem_gnt = 1, 1-cycle latency, rdata = addr, instr_ready = 1 -> instr_pc sequence 0, 4, 8, 12, back to back, instr == instr_pc.
REQ-041 instr_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 entries queued; imem_req low; head 0x0 stable; resume yields 0x0, 0x4, 0x8, 0xC then 0x10.
REQ-042 3 requests outstanding (latency 3), redirect to 0x103 -> next fetch 0x100; 3 stale responses dropped; first instr_pc = 0x100.
REQ-043 Redirect in the same cycle as a response and a pop -> queue empty next cycle; drop = outstanding - 1; no stale PC is ever delivered.
REQ-044 RESET_PC = 0xFFFFFFF8, free run -> instr_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
REQ-045 Reset asserted with a full queue and outstanding requests -> instr_valid = 0 and imem_req = 0 during reset; first fetch at RESET_PC afterward.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: architectural widths, default reset vector and
// the {pc, instr} entry carried by the instruction queue.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between memory response and decode. Simultaneous push/pop is
// legal at any occupancy; flush empties the queue and cancels that cycle's push/pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited requests, in-order responses queued
// with their PC, and redirects that flush the queue and discard stale responses.
module fetch_unit #(
    parameter int                XLEN     = riscv_pkg::XLEN,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            imem_req,
    output logic [XLEN-1:0]                 imem_addr,
    input  logic                            imem_gnt,
    input  logic                            imem_rvalid,
    input  logic [riscv_pkg::INSTR_W-1:0]   imem_rdata,
    input  logic                            redirect_valid,
    input  logic [XLEN-1:0]                 redirect_pc,
    output logic                            instr_valid,
    output logic [riscv_pkg::INSTR_W-1:0]   instr,
    output logic [XLEN-1:0]                 instr_pc,
    input  logic                            instr_ready
);

    import riscv_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  redirect_base;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    logic             accept;
    logic             rsp_ok;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Every queued or in-flight instruction holds one of DEPTH credits, so a
    // response always finds room in the queue.
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign imem_req      = !reset && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr     = fetch_pc;
    assign accept        = imem_req && imem_gnt;
    assign rsp_ok        = imem_rvalid && (outstanding != '0);
    assign push          = rsp_ok && (drop == '0) && !redirect_valid;
    assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

    assign instr_valid = !reset && (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = resp_pc;
        push_entry.instr = imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
            if (redirect_valid) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
                // Everything still in flight after this cycle belongs to the old path.
                drop     <= outstanding - CNT_W'(rsp_ok);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_ok) begin
                    if (drop != '0) drop <= drop - CNT_W'(1);
                    else            resp_pc <= resp_pc + XLEN'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

endmodule
